rtc_burst_writer: RTL and testbench

//  Parametrised write sequencer for the RTC bus controller. It writes a burst of
//  1..MAX_WORDS consecutive registers starting at base_addr, then optionally

---
 rtl/rtc_pkg.sv | 22 ++
 rtl/rtc_timeout_counter.sv | 26 ++
 rtl/rtc_burst_writer.sv | 188 ++++++++++++++++++
 tb/tb_rtc_burst_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus write sequencer: FSM states, error codes,
// and the default transfer-command address/data.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_XFER,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ABORT   = 2'b10
  } err_t;

  localparam logic [7:0] XFER_ADDR_DEF = 8'hF0;
  localparam logic [7:0] XFER_DATA_DEF = 8'hF0;

endpackage

// File: rtl/rtc_timeout_counter.sv
// Counts cycles while enabled; expired flags the TIMEOUT-th enabled cycle.
module rtc_timeout_counter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/rtc_burst_writer.sv
// Writes a burst of consecutive RTC registers via the bus_* handshake, then
// optionally the transfer command; reports timeout/abort status.
module rtc_burst_writer
  import rtc_pkg::*;
#(
  parameter int unsigned     AW        = 8,
  parameter int unsigned     DW        = 8,
  parameter int unsigned     MAX_WORDS = 16,
  parameter bit              XFER_EN   = 1'b1,
  parameter logic [AW-1:0]   XFER_ADDR = AW'(XFER_ADDR_DEF),
  parameter logic [DW-1:0]   XFER_DATA = DW'(XFER_DATA_DEF),
  parameter int unsigned     TIMEOUT   = 1023,
  localparam int unsigned    CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] word_count,
  output logic [CW-1:0] src_idx,
  input  logic [DW-1:0] src_data,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_data,
  output logic          bus_wr,
  output logic          bus_active,
  input  logic          bus_done,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [CW-1:0] words_written
);

  state_t        r_state, w_next;
  logic [AW-1:0] r_base, w_base;
  logic [CW-1:0] r_count, w_count;
  logic [CW-1:0] r_idx, w_idx;
  logic [AW-1:0] r_bus_addr, w_bus_addr;
  logic [DW-1:0] r_bus_data, w_bus_data;
  logic          r_bus_wr, w_bus_wr;
  logic          r_bus_active, w_bus_active;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  err_t          r_err, w_err;
  logic [CW-1:0] r_words, w_words;

  logic [AW-1:0] w_addr;
  logic [CW-1:0] w_idx_inc;
  logic          w_last;
  logic          w_expired;

  assign w_addr    = r_base + AW'(r_idx);
  assign w_idx_inc = r_idx + CW'(1);
  assign w_last    = (w_idx_inc == r_count);

  // The timer measures how long the current request has been held, so it
  // restarts whenever bus_wr is low (between words and before the XFER write).
  rtc_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!r_bus_wr),
    .i_enable  (r_bus_wr),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_bus_addr   <= '0;
      r_bus_data   <= '0;
      r_bus_wr     <= 1'b0;
      r_bus_active <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= ERR_OK;
      r_words      <= '0;
    end else begin
      r_state      <= w_next;
      r_base       <= w_base;
      r_count      <= w_count;
      r_idx        <= w_idx;
      r_bus_addr   <= w_bus_addr;
      r_bus_data   <= w_bus_data;
      r_bus_wr     <= w_bus_wr;
      r_bus_active <= w_bus_active;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
      r_words      <= w_words;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_base     = r_base;
    w_count    = r_count;
    w_idx      = r_idx;
    w_bus_addr = r_bus_addr;
    w_bus_data = r_bus_data;
    w_bus_wr   = r_bus_wr;
    w_err      = r_err;
    w_words    = r_words;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_base  = base_addr;
          w_count = word_count;
          w_idx   = '0;
          w_err   = ERR_OK;
          w_words = '0;
          if (word_count != '0) w_next = ST_FETCH;
          else if (XFER_EN)     w_next = ST_XFER;
          else                  w_next = ST_FINISH;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          w_err  = ERR_ABORT;
          w_next = ST_FINISH;
        end else begin
          w_bus_addr = w_addr;
          w_bus_data = src_data;
          w_bus_wr   = 1'b1;
          w_next     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus_done) begin
          w_bus_wr = 1'b0;
          w_words  = r_words + CW'(1);
          w_idx    = w_idx_inc;
          if (!w_last)      w_next = ST_FETCH;
          else if (XFER_EN) w_next = ST_XFER;
          else              w_next = ST_FINISH;
        end else if (w_expired) begin
          w_err  = ERR_TIMEOUT;
          w_next = ST_FINISH;
        end
        // A completing word is still counted, but abort decides where we go.
        if (abort) begin
          w_err  = ERR_ABORT;
          w_next = ST_FINISH;
        end
      end
      ST_XFER: begin
        if (abort) begin
          w_err  = ERR_ABORT;
          w_next = ST_FINISH;
        end else if (!r_bus_wr) begin
          w_bus_addr = XFER_ADDR;
          w_bus_data = XFER_DATA;
          w_bus_wr   = 1'b1;
        end else if (bus_done) begin
          w_bus_wr = 1'b0;
          w_next   = ST_FINISH;
        end else if (w_expired) begin
          w_err  = ERR_TIMEOUT;
          w_next = ST_FINISH;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase

    if (w_next == ST_FINISH) w_bus_wr = 1'b0;

    w_busy       = (w_next != ST_IDLE);
    w_done       = (w_next == ST_FINISH);
    w_bus_active = (w_next == ST_FETCH) || (w_next == ST_WRITE) || (w_next == ST_XFER);
  end

  assign src_idx       = r_idx;
  assign bus_addr      = r_bus_addr;
  assign bus_data      = r_bus_data;
  assign bus_wr        = r_bus_wr;
  assign bus_active    = r_bus_active;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign words_written = r_words;

endmodule

// File: tb/tb_rtc_burst_writer.sv
// Self-checking bench for rtc_burst_writer: two instances (with/without the
// transfer command), a bus responder model and a write scoreboard.
module tb_rtc_burst_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort, sel;
  logic [7:0] base_addr;
  logic [4:0] word_count;
  logic       model_done, man_done, bus_done;
  assign bus_done = model_done | man_done;

  logic [4:0] a_src_idx, b_src_idx, a_words, b_words;
  logic [7:0] a_src_data, b_src_data, a_addr, b_addr, a_data, b_data;
  logic       a_wr, b_wr, a_active, b_active, a_busy, b_busy, a_done, b_done;
  logic [1:0] a_err, b_err;

  assign a_src_data = 8'({3'b000, a_src_idx} << 4);
  assign b_src_data = 8'({3'b000, b_src_idx} << 4);

  rtc_burst_writer #(.XFER_EN(1'b1), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort & ~sel),
    .base_addr(base_addr), .word_count(word_count), .src_idx(a_src_idx),
    .src_data(a_src_data), .bus_addr(a_addr), .bus_data(a_data), .bus_wr(a_wr),
    .bus_active(a_active), .bus_done(bus_done & ~sel), .busy(a_busy),
    .done(a_done), .err(a_err), .words_written(a_words));

  rtc_burst_writer #(.XFER_EN(1'b0), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .abort(abort & sel),
    .base_addr(base_addr), .word_count(word_count), .src_idx(b_src_idx),
    .src_data(b_src_data), .bus_addr(b_addr), .bus_data(b_data), .bus_wr(b_wr),
    .bus_active(b_active), .bus_done(bus_done & sel), .busy(b_busy),
    .done(b_done), .err(b_err), .words_written(b_words));

  logic       m_wr, m_active, m_busy, m_done;
  logic [7:0] m_addr, m_data;
  logic [1:0] m_err;
  logic [4:0] m_words;
  assign m_wr     = sel ? b_wr     : a_wr;
  assign m_active = sel ? b_active : a_active;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_done   = sel ? b_done   : a_done;
  assign m_addr   = sel ? b_addr   : a_addr;
  assign m_data   = sel ? b_data   : a_data;
  assign m_err    = sel ? b_err    : a_err;
  assign m_words  = sel ? b_words  : a_words;

  int checks = 0;
  int failures = 0;
  int done_delay = 0;
  int done_cnt = 0;
  int last_wr_len = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    bit         sel;
    logic [7:0] base;
    logic [4:0] cnt;
    int         delay;
    logic [1:0] err;
    logic [4:0] words;
    int         wr_len;
  } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Bus controller model: pulses bus_done after bus_wr has been high done_delay cycles.
  initial begin
    int age;
    age = 0;
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (m_wr && done_delay != 0) begin
        age++;
        if (age == done_delay) begin
          model_done = 1'b1;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Write monitor: pops the scoreboard on every new request.
  initial begin
    logic prev_wr;
    int   len;
    logic [15:0] e;
    prev_wr = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (m_wr && !prev_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got=%h,%h exp=none", m_addr, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_addr, m_data} !== e) begin
            failures++;
            $display("FAIL write got=%h,%h exp=%h,%h", m_addr, m_data, e[15:8], e[7:0]);
          end
        end
      end
      if (m_wr) len++;
      else if (prev_wr) begin
        last_wr_len = len;
        len = 0;
      end
      if (m_done) done_cnt++;
      prev_wr = m_wr;
    end
  end

  task automatic wait_wr(input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (m_wr) ok = 1'b1;
      else tick();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (m_done) ok = 1'b1;
      else tick();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic begin_burst(input logic [7:0] b, input logic [4:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int d0;
    logic [7:0] a;
    sel = v.sel;
    done_delay = v.delay;
    if (v.err == 2'd0) begin
      for (int i = 0; i < int'(v.cnt); i++) begin
        a = v.base + 8'(i);
        exp_q.push_back({a, 8'(i * 16)});
      end
      if (!v.sel) exp_q.push_back(16'hF0F0);
    end else if (v.cnt != 5'd0) begin
      exp_q.push_back({v.base, 8'h00});
    end else if (!v.sel) begin
      exp_q.push_back(16'hF0F0);
    end
    tick();
    d0 = done_cnt;
    begin_burst(v.base, v.cnt);
    chk($sformatf("v%0d_busy", k), 32'(m_busy), 32'd1);
    wait_done($sformatf("v%0d_done_seen", k));
    chk($sformatf("v%0d_err", k), 32'(m_err), 32'(v.err));
    chk($sformatf("v%0d_words", k), 32'(m_words), 32'(v.words));
    tick();
    chk($sformatf("v%0d_idle", k), 32'({m_busy, m_wr, m_active}), 32'd0);
    chk($sformatf("v%0d_done_pulses", k), 32'(done_cnt - d0), 32'd1);
    chk($sformatf("v%0d_queue_left", k), 32'(exp_q.size()), 32'd0);
    if (v.wr_len > 0) chk($sformatf("v%0d_wr_len", k), 32'(last_wr_len), 32'(v.wr_len));
    exp_q.delete();
  endtask

  task automatic abort_seq(input bit with_done);
    int d0;
    sel = 1'b0;
    done_delay = 0;
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h4110);
    tick();
    d0 = done_cnt;
    begin_burst(8'h40, 5'd3);
    wait_wr("ab_wr0");
    chk("ab_active", 32'(m_active), 32'd1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    wait_wr("ab_wr1");
    abort = 1'b1;
    man_done = with_done;
    tick();
    abort = 1'b0;
    man_done = 1'b0;
    wait_done("ab_done_seen");
    chk("ab_err", 32'(m_err), 32'd2);
    chk("ab_words", 32'(m_words), with_done ? 32'd2 : 32'd1);
    repeat (4) tick();
    chk("ab_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("ab_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; man_done = 1'b0;
    base_addr = '0; word_count = '0;

    vecs[0] = '{1'b0, 8'h21, 5'd3,  4, 2'd0, 5'd3,  4};
    vecs[1] = '{1'b1, 8'hFE, 5'd3,  4, 2'd0, 5'd3,  4};
    vecs[2] = '{1'b0, 8'h00, 5'd0,  2, 2'd0, 5'd0,  2};
    vecs[3] = '{1'b0, 8'h21, 5'd2,  0, 2'd1, 5'd0,  8};
    vecs[4] = '{1'b1, 8'hF8, 5'd16, 1, 2'd0, 5'd16, 1};
    vecs[5] = '{1'b0, 8'h7F, 5'd1,  3, 2'd0, 5'd1,  3};
    vecs[6] = '{1'b1, 8'h10, 5'd0,  1, 2'd0, 5'd0, -1};
    vecs[7] = '{1'b1, 8'h30, 5'd2,  0, 2'd1, 5'd0,  8};

    repeat (3) tick();
    chk("reset_a", 32'({a_src_idx, a_addr, a_data, a_wr, a_active, a_busy, a_done, a_err, a_words}), 32'd0);
    chk("reset_b", 32'({b_src_idx, b_addr, b_data, b_wr, b_active, b_busy, b_done, b_err, b_words}), 32'd0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    abort_seq(1'b0);
    abort_seq(1'b1);

    // Reset in WRITE: bus_wr drops on the next edge and every output clears.
    sel = 1'b0;
    done_delay = 0;
    exp_q.push_back(16'h5000);
    begin_burst(8'h50, 5'd2);
    wait_wr("rst_wr");
    reset = 1'b1;
    tick();
    chk("rst_outputs", 32'({a_src_idx, a_addr, a_data, a_wr, a_active, a_busy, a_done, a_err, a_words}), 32'd0);
    reset = 1'b0;
    chk("rst_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    d0 = done_cnt;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    repeat (3) tick();
    chk("stray_done_idle", 32'({m_busy, m_wr, m_done}), 32'd0);
    chk("stray_done_pulses", 32'(done_cnt - d0), 32'd0);

    // start held for the whole burst must not queue a second one.
    done_delay = 2;
    exp_q.push_back(16'h6000);
    exp_q.push_back(16'hF0F0);
    base_addr = 8'h60;
    word_count = 5'd1;
    start = 1'b1;
    tick();
    wait_done("hold_done_seen");
    start = 1'b0;
    repeat (10) tick();
    chk("hold_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("hold_idle", 32'({m_busy, m_wr}), 32'd0);
    chk("hold_words", 32'(m_words), 32'd1);
    chk("hold_err", 32'(m_err), 32'd0);
    chk("hold_queue_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
